lut_neuron_layer_pipe: RTL and testbench

Parametrised, runtime-programmable successor to the fixed-ROM LogicNets neuron. Holds NUM_NEURONS independent truth tables of 2^IN_BITS entries × OUT_BITS bits each. Tables are loaded through a config write port. Each accepted input vector produces one registered output vector behind a valid/ready handshake. The block sits between quantised activation layers in the qubit-readout classifier pipeline.

---
 rtl/lut_neuron_layer_pipe.sv | 122 ++++++++++++
 tb/tb_lut_neuron_layer_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_neuron_layer_pipe.sv
// lut_neuron_layer_pipe: NUM_NEURONS runtime-programmable truth tables,
// each 2^IN_BITS entries of OUT_BITS bits, looked up in parallel behind a
// single registered valid/ready output stage. Tables are written through a
// config port that is always open, independent of the data handshake.
// Optional feature macro: LUT_PARITY_EN adds an even-parity bit per entry
// and a sticky lut_err flag raised when a looked-up entry fails its parity.
module lut_neuron_layer_pipe #(
  parameter int IN_BITS      = 7,
  parameter int OUT_BITS     = 2,
  parameter int NUM_NEURONS  = 4,
  parameter int NEURON_IDX_W = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_NEURONS*IN_BITS-1:0]  in_addr,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
  input  logic                            cfg_we,
  input  logic [NEURON_IDX_W-1:0]         cfg_neuron,
  input  logic [IN_BITS-1:0]              cfg_addr,
  input  logic [OUT_BITS-1:0]             cfg_data,
  output logic [15:0]                     cfg_count,
  output logic                            lut_err
);

  localparam int DEPTH = 1 << IN_BITS;

  logic [NUM_NEURONS-1:0][DEPTH-1:0][OUT_BITS-1:0] lut_mem;
  logic [NUM_NEURONS*OUT_BITS-1:0]                 lookup_data;
  logic                                            cfg_hit;
  logic                                            accept;
  logic                                            ready_en;

  // Codes at or above NUM_NEURONS address no table and are dropped.
  assign cfg_hit  = (int'(cfg_neuron) < NUM_NEURONS);
  assign in_ready = ready_en && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Table storage: single write port, cleared as a whole on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_mem <= '0;
    end else if (cfg_we && cfg_hit) begin
      lut_mem[cfg_neuron][cfg_addr] <= cfg_data;
    end
  end

  // Asynchronous read of every neuron's table; a same-edge write is not yet visible.
  always_comb begin
    lookup_data = '0;
    for (int k = 0; k < NUM_NEURONS; k++) begin
      lookup_data[k*OUT_BITS +: OUT_BITS] = lut_mem[k][in_addr[k*IN_BITS +: IN_BITS]];
    end
  end

  // Saturating count of config writes that actually landed in a table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_count <= '0;
    end else if (cfg_we && cfg_hit && (cfg_count != 16'hFFFF)) begin
      cfg_count <= cfg_count + 16'd1;
    end
  end

  // Output register stage; ready_en keeps in_ready low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= lookup_data;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef LUT_PARITY_EN
  logic [NUM_NEURONS-1:0][DEPTH-1:0] par_mem;
  logic [NUM_NEURONS-1:0]            par_bad;
  logic                              lut_err_q;

  // Even-parity shadow of each entry, written alongside the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_mem <= '0;
    end else if (cfg_we && cfg_hit) begin
      par_mem[cfg_neuron][cfg_addr] <= ^cfg_data;
    end
  end

  // Recompute parity of each neuron's looked-up entry and compare with the stored bit.
  always_comb begin
    par_bad = '0;
    for (int k = 0; k < NUM_NEURONS; k++) begin
      par_bad[k] = (^lookup_data[k*OUT_BITS +: OUT_BITS]) ^
                   par_mem[k][in_addr[k*IN_BITS +: IN_BITS]];
    end
  end

  // Sticky error, set on the same edge that registers the offending lookup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_err_q <= 1'b0;
    end else if (accept && (|par_bad)) begin
      lut_err_q <= 1'b1;
    end
  end

  assign lut_err = lut_err_q;
`else
  assign lut_err = 1'b0;
`endif

endmodule

// File: tb/tb_lut_neuron_layer_pipe.sv
// tb_lut_neuron_layer_pipe: directed test of lut_neuron_layer_pipe with
// hand-computed expectations. A second instance with NUM_NEURONS = 3 gives
// the 2-bit neuron select an unused code to exercise.
module tb_lut_neuron_layer_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [27:0] in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        cfg_we;
  logic [1:0]  cfg_neuron;
  logic [6:0]  cfg_addr;
  logic [1:0]  cfg_data;
  logic [15:0] cfg_count;
  logic        lut_err;

  logic        in_valid3;
  logic        in_ready3;
  logic [20:0] in_addr3;
  logic        out_valid3;
  logic        out_ready3;
  logic [5:0]  out_data3;
  logic        cfg_we3;
  logic [1:0]  cfg_neuron3;
  logic [6:0]  cfg_addr3;
  logic [1:0]  cfg_data3;
  logic [15:0] cfg_count3;
  logic        lut_err3;

  int n_checks;
  int n_fail;

  lut_neuron_layer_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .cfg_we     (cfg_we),
    .cfg_neuron (cfg_neuron),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_count  (cfg_count),
    .lut_err    (lut_err)
  );

  lut_neuron_layer_pipe #(.NUM_NEURONS(3), .NEURON_IDX_W(2)) dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid3),
    .in_ready   (in_ready3),
    .in_addr    (in_addr3),
    .out_valid  (out_valid3),
    .out_ready  (out_ready3),
    .out_data   (out_data3),
    .cfg_we     (cfg_we3),
    .cfg_neuron (cfg_neuron3),
    .cfg_addr   (cfg_addr3),
    .cfg_data   (cfg_data3),
    .cfg_count  (cfg_count3),
    .lut_err    (lut_err3)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [27:0] mk_addr(input logic [6:0] a0, input logic [6:0] a1,
                                          input logic [6:0] a2, input logic [6:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] n, input logic [6:0] a, input logic [1:0] d);
    cfg_we     = 1'b1;
    cfg_neuron = n;
    cfg_addr   = a;
    cfg_data   = d;
    tick();
    cfg_we     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #8;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_ready got %b expected 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid got %b expected 0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_out_data got %h expected 00", out_data); end
    n_checks++; if (cfg_count !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_cfg_count got %h expected 0000", cfg_count); end
    n_checks++; if (lut_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_lut_err got %b expected 0", lut_err); end
    #4;
    rst_n = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_in_ready got %b expected 1", in_ready); end
  endtask

  task automatic test_basic_lookup();
    cfg_write(2'd0, 7'h40, 2'b11);
    cfg_write(2'd3, 7'h7F, 2'b01);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_addr   = mk_addr(7'h40, 7'h00, 7'h00, 7'h7F);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_pre_valid got %b expected 0", out_valid); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_valid got %b expected 1", out_valid); end
    n_checks++; if (out_data !== 8'h43) begin n_fail++; $display("[TB] FAIL basic_data got %h expected 43", out_data); end
    n_checks++; if (cfg_count !== 16'd2) begin n_fail++; $display("[TB] FAIL basic_cfg_count got %0d expected 2", cfg_count); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_drain_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [1:0] val;
    for (int v = 1; v <= 6; v++) begin
      val = 2'(((v - 1) % 3) + 1);
      cfg_write(2'd2, 7'(v), val);
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_addr   = mk_addr(7'h00, 7'h00, 7'd1, 7'h00);
    tick();
    n_checks++; if (out_data !== 8'h10 || out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_first got valid %b data %h expected 1 10", out_valid, out_data); end
    in_addr = mk_addr(7'h00, 7'h00, 7'd2, 7'h00);
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_stall_ready cycle %0d got %b expected 0", c, in_ready); end
      n_checks++; if (out_data !== 8'h10 || out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_stall_hold cycle %0d got valid %b data %h expected 1 10", c, out_valid, out_data); end
    end
    out_ready = 1'b1;
    for (int v = 2; v <= 6; v++) begin
      in_addr = mk_addr(7'h00, 7'h00, 7'(v), 7'h00);
      val = 2'(((v - 1) % 3) + 1);
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_data !== {2'b00, val, 4'b0000}) begin n_fail++; $display("[TB] FAIL bp_drain vec %0d got valid %b data %h expected 1 %h", v, out_valid, out_data, {2'b00, val, 4'b0000}); end
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_idle_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_collision();
    out_ready  = 1'b1;
    cfg_we     = 1'b1;
    cfg_neuron = 2'd1;
    cfg_addr   = 7'h05;
    cfg_data   = 2'b10;
    in_valid   = 1'b1;
    in_addr    = mk_addr(7'h00, 7'h05, 7'h00, 7'h00);
    tick();
    cfg_we = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h00) begin n_fail++; $display("[TB] FAIL collision_old got valid %b data %h expected 1 00", out_valid, out_data); end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_checks++; if (out_data !== 8'h08) begin n_fail++; $display("[TB] FAIL collision_new got %h expected 08", out_data); end
    cfg_write(2'd1, 7'h05, 2'b01);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h08) begin n_fail++; $display("[TB] FAIL registered_output_kept got valid %b data %h expected 1 08", out_valid, out_data); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (cfg_count !== 16'd10) begin n_fail++; $display("[TB] FAIL collision_cfg_count got %0d expected 10", cfg_count); end
  endtask

  task automatic test_out_of_range();
    cfg_we3     = 1'b1;
    cfg_neuron3 = 2'd3;
    cfg_addr3   = 7'h22;
    cfg_data3   = 2'b11;
    tick();
    cfg_we3 = 1'b0;
    n_checks++; if (cfg_count3 !== 16'd0) begin n_fail++; $display("[TB] FAIL oor_cfg_count got %0d expected 0", cfg_count3); end
    in_valid3 = 1'b1;
    in_addr3  = {7'h22, 7'h22, 7'h22};
    tick();
    in_valid3 = 1'b0;
    n_checks++; if (out_data3 !== 6'h00) begin n_fail++; $display("[TB] FAIL oor_table_unchanged got %h expected 00", out_data3); end
    cfg_we3     = 1'b1;
    cfg_neuron3 = 2'd2;
    tick();
    cfg_we3 = 1'b0;
    n_checks++; if (cfg_count3 !== 16'd1) begin n_fail++; $display("[TB] FAIL inrange_cfg_count got %0d expected 1", cfg_count3); end
    in_valid3 = 1'b1;
    tick();
    in_valid3 = 1'b0;
    n_checks++; if (out_data3 !== 6'h30) begin n_fail++; $display("[TB] FAIL inrange_lookup got %h expected 30", out_data3); end
  endtask

  task automatic test_saturation();
    cfg_we     = 1'b1;
    cfg_neuron = 2'd0;
    cfg_addr   = 7'h00;
    cfg_data   = 2'b00;
    for (int i = 0; i < 65524; i++) tick();
    n_checks++; if (cfg_count !== 16'hFFFE) begin n_fail++; $display("[TB] FAIL sat_near got %h expected FFFE", cfg_count); end
    for (int i = 0; i < 4476; i++) tick();
    cfg_we = 1'b0;
    n_checks++; if (cfg_count !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL sat_hold got %h expected FFFF", cfg_count); end
  endtask

  task automatic test_parity();
    logic exp_err;
    cfg_write(2'd2, 7'h11, 2'b01);
`ifdef LUT_PARITY_EN
    dut.par_mem[2][7'h11] = ~dut.par_mem[2][7'h11];
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_addr   = mk_addr(7'h00, 7'h00, 7'h11, 7'h00);
    tick();
    n_checks++; if (out_data !== 8'h10) begin n_fail++; $display("[TB] FAIL parity_data got %h expected 10", out_data); end
    n_checks++; if (lut_err !== exp_err) begin n_fail++; $display("[TB] FAIL parity_err got %b expected %b", lut_err, exp_err); end
    in_addr = mk_addr(7'h00, 7'h00, 7'd1, 7'h00);
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_data !== 8'h10) begin n_fail++; $display("[TB] FAIL parity_clean_data got %h expected 10", out_data); end
    n_checks++; if (lut_err !== exp_err) begin n_fail++; $display("[TB] FAIL parity_sticky got %b expected %b", lut_err, exp_err); end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_addr   = mk_addr(7'h40, 7'h00, 7'h00, 7'h7F);
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h43) begin n_fail++; $display("[TB] FAIL mid_pre got valid %b data %h expected 1 43", out_valid, out_data); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_async_valid got %b expected 0", out_valid); end
    n_checks++; if (cfg_count !== 16'd0 || lut_err !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_async_state got count %h err %b expected 0000 0", cfg_count, lut_err); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_in_ready got %b expected 0", in_ready); end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_release_ready got %b expected 1", in_ready); end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h00) begin n_fail++; $display("[TB] FAIL mid_cleared_table got valid %b data %h expected 1 00", out_valid, out_data); end
  endtask

  // Drive every scenario in order, then report.
  initial begin
    n_checks    = 0;
    n_fail      = 0;
    in_valid    = 1'b0;
    in_addr     = '0;
    out_ready   = 1'b1;
    cfg_we      = 1'b0;
    cfg_neuron  = '0;
    cfg_addr    = '0;
    cfg_data    = '0;
    in_valid3   = 1'b0;
    in_addr3    = '0;
    out_ready3  = 1'b1;
    cfg_we3     = 1'b0;
    cfg_neuron3 = '0;
    cfg_addr3   = '0;
    cfg_data3   = '0;
    test_reset();
    test_basic_lookup();
    test_backpressure();
    test_collision();
    test_out_of_range();
    test_saturation();
    test_parity();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
